// File: rtl/unified_mem_router_if.sv
// unified_mem_router_if: core-side requester and memory-port signals of the unified memory router.
// slave is the router's view; master is the core/memory side that drives requests and read data.
interface unified_mem_router_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              if_stall;
    logic              dm_stall;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              dm_valid;
    logic [31:0]       dm_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output if_stall, dm_stall, if_valid, if_rdata, dm_valid, dm_rdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  if_stall, dm_stall, if_valid, if_rdata, dm_valid, dm_rdata
    );
endinterface

// File: rtl/unified_mem_router.sv
// unified_mem_router: arbitrates IF fetches and DM loads/stores onto one memory port and steers responses back.
// Optional MEM_ROUTER_PERF_EN adds a conflict_cnt output counting cycles where both requesters are active.
module unified_mem_router #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_router_if.slave  bus
`ifdef MEM_ROUTER_PERF_EN
    ,
    output logic [31:0]          conflict_cnt
`endif
);
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_LD, TAG_ST} tag_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    tag_e              tag_q, tag_d;
    logic [3:0]        starve_q, starve_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_win, dm_win;
    logic [ADDR_W-1:0] addr_sel;

    always_comb begin
        if_win         = bus.if_req & (!bus.dm_req | starve_q == LIMIT);
        dm_win         = bus.dm_req & !if_win;
        addr_sel       = dm_win ? bus.dm_addr : bus.if_addr;
        bus.mem_en     = bus.if_req | bus.dm_req;
        bus.mem_we     = dm_win & bus.dm_we;
        bus.mem_addr   = addr_sel;
        bus.mem_wdata  = bus.dm_wdata;
        bus.if_stall   = bus.if_req & !if_win;
        bus.dm_stall   = bus.dm_req & !dm_win;
        starve_d       = !bus.if_stall ? 4'd0 : (starve_q == LIMIT ? starve_q : starve_q + 4'd1);
        tag_d          = if_win ? TAG_IF : (dm_win ? (bus.dm_we ? TAG_ST : TAG_LD) : TAG_NONE);
        // A response landing while rst is high belongs to a request being discarded.
        bus.if_valid   = !rst & (tag_q == TAG_IF);
        bus.dm_valid   = !rst & (tag_q == TAG_LD | tag_q == TAG_ST);
        if_rdata_d     = bus.if_valid ? bus.mem_rdata : if_rdata_q;
        dm_rdata_d     = (!rst & tag_q == TAG_LD) ? bus.mem_rdata : dm_rdata_q;
        bus.if_rdata   = if_rdata_d;
        bus.dm_rdata   = dm_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= TAG_NONE;
            starve_q   <= 4'd0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else begin
            tag_q      <= tag_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

`ifdef MEM_ROUTER_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q + {31'd0, bus.if_req & bus.dm_req};
        conflict_cnt   = conflict_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) conflict_cnt_q <= 32'h0;
        else     conflict_cnt_q <= conflict_cnt_d;
    end
`endif
endmodule
